// File: rtl/rsp_skid_fifo.sv
// Memory-response elastic buffer: DEPTH-entry ring plus a registered output stage, valid/ready both sides.
// Optional RSP_SKID_FIFO_HWM_EN adds a registered high-water mark of the occupancy.
module rsp_skid_fifo #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 4,
  parameter  int AFULL_THRESH = DEPTH,
  localparam int CNT_W        = $clog2(DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  m_rsp_vld,
  output logic                  m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic [CNT_W-1:0]      count,
`ifdef RSP_SKID_FIFO_HWM_EN
  output logic [CNT_W-1:0]      hwm,
`endif
  output logic                  almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] AFULL = CNT_W'(AFULL_THRESH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] ring_q, ring_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]         ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  src_vld_q, src_vld_d;
  logic [DATA_WIDTH-1:0] src_data_q, src_data_d;
  logic                  push, pop, load, ring_rd, ring_wr, bypass;

  assign m_rsp_rdy   = !rst && !flush && (count_q != FULL);
  assign push        = m_rsp_vld && m_rsp_rdy;
  assign pop         = src_vld_q && src_rdy;
  assign load        = !src_vld_q || pop;
  assign src_vld     = src_vld_q;
  assign src_data    = src_data_q;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL);

  always_comb begin
    src_vld_d  = src_vld_q;
    src_data_d = src_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ring_d     = ring_q;
    ring_rd    = 1'b0;
    ring_wr    = 1'b0;
    bypass     = 1'b0;
    // Ring drains ahead of the bypass so order holds; the output is empty only when the ring is.
    if (load) begin
      if (ring_cnt_q != '0) begin
        src_data_d = ring_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + PW'(1);
        src_vld_d  = 1'b1;
        ring_rd    = 1'b1;
      end else if (push) begin
        src_data_d = m_rsp_data;
        src_vld_d  = 1'b1;
        bypass     = 1'b1;
      end else begin
        src_vld_d  = 1'b0;
      end
    end
    if (push && !bypass) begin
      ring_d[wr_ptr_q] = m_rsp_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      ring_wr          = 1'b1;
    end
    ring_cnt_d = ring_cnt_q + RW'(ring_wr) - RW'(ring_rd);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      src_vld_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      ring_cnt_d = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ring_cnt_q <= '0;
      count_q    <= '0;
      src_vld_q  <= 1'b0;
      src_data_q <= '0;
    end else begin
      ring_q     <= ring_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ring_cnt_q <= ring_cnt_d;
      count_q    <= count_d;
      src_vld_q  <= src_vld_d;
      src_data_q <= src_data_d;
    end
  end

`ifdef RSP_SKID_FIFO_HWM_EN
  // Survives flush so a whole kernel run (including aborts) stays visible.
  logic [CNT_W-1:0] hwm_q, hwm_d;
  assign hwm = hwm_q;

  always_comb begin
    hwm_d = hwm_q;
    if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end
`endif

endmodule

// File: tb/tb_rsp_skid_fifo.sv
// Directed bench for rsp_skid_fifo (DEPTH=4, capacity 5), scenario tasks with inline checks.
module tb_rsp_skid_fifo;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          m_rsp_vld = 1'b0;
  logic          m_rsp_rdy;
  logic [DW-1:0] m_rsp_data = '0;
  logic          src_vld;
  logic          src_rdy = 1'b0;
  logic [DW-1:0] src_data;
  logic [CW-1:0] count;
  logic          almost_full;
`ifdef RSP_SKID_FIFO_HWM_EN
  logic [CW-1:0] hwm;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rsp_skid_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .AFULL_THRESH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_data(src_data),
    .count(count),
`ifdef RSP_SKID_FIFO_HWM_EN
    .hwm(hwm),
`endif
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (src_vld !== 1'b0)   begin n_err++; $display("FAIL rst_src_vld got %0b want 0", src_vld); end
    n_cmp++; if (src_data !== '0)    begin n_err++; $display("FAIL rst_src_data got %h want 0", src_data); end
    n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (m_rsp_rdy !== 1'b0) begin n_err++; $display("FAIL rst_m_rsp_rdy got %0b want 0", m_rsp_rdy); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_afull got %0b want 0", almost_full); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (m_rsp_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_rdy got %0b want 1", m_rsp_rdy); end
  endtask

  task automatic test_single();
    src_rdy = 1'b1; m_rsp_vld = 1'b1; m_rsp_data = 32'hA5A5_0001;
    step();
    m_rsp_vld = 1'b0;
    n_cmp++; if (src_vld !== 1'b1)          begin n_err++; $display("FAIL single_vld got %0b want 1", src_vld); end
    n_cmp++; if (src_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_data got %h want a5a50001", src_data); end
    n_cmp++; if (count !== 3'd1)            begin n_err++; $display("FAIL single_count got %0d want 1", count); end
    step();
    n_cmp++; if (src_vld !== 1'b0) begin n_err++; $display("FAIL single_drain_vld got %0b want 0", src_vld); end
    n_cmp++; if (count !== 3'd0)   begin n_err++; $display("FAIL single_drain_count got %0d want 0", count); end
  endtask

  task automatic test_fill_full();
    src_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'h10 + i;
      step();
    end
    m_rsp_data = 32'h15;
    #1;
    n_cmp++; if (count !== 3'd5)       begin n_err++; $display("FAIL full_count got %0d want 5", count); end
    n_cmp++; if (m_rsp_rdy !== 1'b0)   begin n_err++; $display("FAIL full_rdy got %0b want 0", m_rsp_rdy); end
    n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_afull got %0b want 1", almost_full); end
    step(); step();
    n_cmp++; if (count !== 3'd5)    begin n_err++; $display("FAIL full_hold_count got %0d want 5", count); end
    n_cmp++; if (src_data !== 32'h10) begin n_err++; $display("FAIL full_hold_data got %h want 10", src_data); end
    m_rsp_vld = 1'b0;
    src_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (src_vld !== 1'b1 || src_data !== 32'h10 + i) begin
        n_err++; $display("FAIL drain_order beat %0d got vld=%0b data=%h want 1/%h", i, src_vld, src_data, 32'h10 + i);
      end
      step();
    end
    n_cmp++; if (src_vld !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_empty got vld=%0b cnt=%0d want 0/0", src_vld, count); end
  endtask

  task automatic test_stream();
    src_rdy = 1'b1; m_rsp_vld = 1'b1; m_rsp_data = 32'd0;
    step();
    for (int i = 1; i < 100; i++) begin
      m_rsp_data = i;
      n_cmp++;
      if (src_vld !== 1'b1 || src_data !== DW'(i - 1) || count !== 3'd1) begin
        n_err++; $display("FAIL stream beat %0d got vld=%0b data=%0d cnt=%0d want 1/%0d/1", i, src_vld, src_data, count, i - 1);
      end
      step();
    end
    m_rsp_vld = 1'b0;
    n_cmp++; if (src_data !== 32'd99) begin n_err++; $display("FAIL stream_last got %0d want 99", src_data); end
    step();
    n_cmp++; if (src_vld !== 1'b0) begin n_err++; $display("FAIL stream_end_vld got %0b want 0", src_vld); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int sent = 0, got = 0, cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          exp_rdy;
    while (got < 64 && cyc < 2000) begin
      src_rdy    = ($urandom_range(0, 1) == 1);
      m_rsp_vld  = (sent < 64) && ($urandom_range(0, 3) != 0);
      m_rsp_data = $urandom;
      #1;
      exp_rdy = (q.size() != 5);
      n_cmp++; if (m_rsp_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd_rdy cyc %0d got %0b want %0b", cyc, m_rsp_rdy, exp_rdy); end
      n_cmp++; if (count !== CW'(q.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, count, q.size()); end
      n_cmp++; if (src_vld !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_vld cyc %0d got %0b want %0b", cyc, src_vld, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (src_data !== q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, src_data, q[0]); end
      end
      if (prev_stall) begin
        n_cmp++; if (src_data !== prev_data) begin n_err++; $display("FAIL rnd_stall_hold cyc %0d got %h want %h", cyc, src_data, prev_data); end
      end
      prev_stall = (q.size() != 0) && !src_rdy;
      prev_data  = src_data;
      if (q.size() != 0 && src_rdy) begin void'(q.pop_front()); got++; end
      if (m_rsp_vld && exp_rdy) begin q.push_back(m_rsp_data); sent++; end
      step();
      cyc++;
    end
    n_cmp++; if (got != 64) begin n_err++; $display("FAIL rnd_timeout got %0d beats want 64", got); end
    m_rsp_vld = 1'b0; src_rdy = 1'b1;
    step();
  endtask

  task automatic test_flush();
    src_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'h31 + i;
      step();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; m_rsp_data = 32'hDEAD;
    #1;
    n_cmp++; if (m_rsp_rdy !== 1'b0) begin n_err++; $display("FAIL flush_rdy got %0b want 0", m_rsp_rdy); end
    step();
    flush = 1'b0; m_rsp_data = 32'hBEEF; src_rdy = 1'b1;
    n_cmp++; if (count !== 3'd0 || src_vld !== 1'b0) begin n_err++; $display("FAIL flush_clear got cnt=%0d vld=%0b want 0/0", count, src_vld); end
    step();
    m_rsp_vld = 1'b0;
    n_cmp++; if (src_vld !== 1'b1 || src_data !== 32'hBEEF || count !== 3'd1) begin
      n_err++; $display("FAIL flush_next got vld=%0b data=%h cnt=%0d want 1/beef/1", src_vld, src_data, count);
    end
    step();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_drain got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; #2; rst = 1'b0;
    src_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rsp_vld = 1'b1; m_rsp_data = 32'h41 + i;
      step();
    end
    n_cmp++; if (count !== 3'd4 || almost_full !== 1'b1) begin n_err++; $display("FAIL mid_pre got cnt=%0d af=%0b want 4/1", count, almost_full); end
`ifdef RSP_SKID_FIFO_HWM_EN
    n_cmp++; if (hwm !== 3'd4) begin n_err++; $display("FAIL hwm_pre got %0d want 4", hwm); end
`endif
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (src_vld !== 1'b0 || src_data !== '0 || count !== 3'd0) begin
      n_err++; $display("FAIL mid_rst got vld=%0b data=%h cnt=%0d want 0/0/0", src_vld, src_data, count);
    end
    n_cmp++; if (almost_full !== 1'b0 || m_rsp_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got af=%0b rdy=%0b want 0/0", almost_full, m_rsp_rdy); end
`ifdef RSP_SKID_FIFO_HWM_EN
    n_cmp++; if (hwm !== 3'd0) begin n_err++; $display("FAIL hwm_rst got %0d want 0", hwm); end
`endif
    m_rsp_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (src_vld !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mid_after got vld=%0b cnt=%0d want 0/0", src_vld, count); end
  endtask

  initial begin
    #3;
    test_reset();
    test_single();
    test_fill_full();
    test_stream();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rsp_skid_fifo.md
Name: rsp_skid_fifo

Overview:
- Parametrised successor to the single-entry memory-response skid stage: a DEPTH-deep elastic buffer between the memory response channel and the consumer (fetcher/LSU).
- Full valid/ready on both sides. Upstream gets a real ready (m_rsp_rdy), so responses are never dropped.
- Registered output stage plus a circular buffer; order-preserving; synchronous flush for kernel abort.
- Occupancy and almost-full outputs for upstream credit/issue throttling.

Parameters:
- DATA_WIDTH, 32 (constants_pkg DATA_WIDTH): response data width.
- DEPTH, 4: ring entries; power of two, >=2. Total capacity is DEPTH+1 (ring plus output register).
- AFULL_THRESH, DEPTH: almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH+1.
- CNT_W, $clog2(DEPTH+2): derived, not overridable; width of count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- m_rsp_vld  in  1  memory response valid.
- m_rsp_rdy  out  1  buffer can accept; = !rst && !flush && (count != DEPTH+1); no combinational dependence on src_rdy.
- m_rsp_data  in  DATA_WIDTH  memory response data.
- src_vld  out  1  registered; head data valid to consumer.
- src_rdy  in  1  consumer accepts.
- src_data  out  DATA_WIDTH  registered head data.
- count  out  CNT_W  registered occupancy, 0..DEPTH+1.
- almost_full  out  1  count >= AFULL_THRESH.

Behaviour:
- Reset (async assert, any time incl. mid-burst): src_vld=0, src_data=0, rd_ptr=wr_ptr=0, count=0, almost_full=0, m_rsp_rdy=0 while rst is high. All contents are lost.
- Definitions: push = m_rsp_vld && m_rsp_rdy; pop = src_vld && src_rdy.
- Output register load: when !src_vld || pop:
  - ring non-empty: load ring[rd_ptr], rd_ptr++, src_vld=1;
  - else if push: load m_rsp_data directly (bypass ring), src_vld=1;
  - else src_vld=0.
- Push not consumed by the bypass writes ring[wr_ptr], wr_ptr++.
- Pointers are log2(DEPTH) bits and wrap naturally. Ring count is tracked explicitly, so full/empty are unambiguous.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: a push at edge N on an empty buffer gives src_vld=1 with that data after edge N (1 cycle). Sustained 1 beat/cycle when src_rdy is held high.
- Hold rule: while src_vld && !src_rdy, src_data and src_vld stay stable.
- Full (count == DEPTH+1): m_rsp_rdy=0 even if pop occurs the same cycle. The freed slot is visible next cycle.
- Empty with push and src_rdy: data bypasses to the output register; count becomes 1.
- Ordering: strict FIFO across bypass and ring paths. Bypass only occurs when the ring is empty.
- flush (priority below rst): next edge gives src_vld=0, pointers 0, count 0. m_rsp_rdy=0 during flush, so no beat is accepted. A pop in the flush cycle is still a completed transfer for the consumer.
- m_rsp_vld while m_rsp_rdy=0: not accepted. Upstream holds data per valid/ready; no error is raised.

Optional Feature:
- Macro RSP_SKID_FIFO_HWM_EN.
- Defined: extra output port hwm [CNT_W-1:0], a registered high-water mark. Updates to count_next when count_next > hwm. Cleared by rst only, not by flush.
- Undefined: no hwm port and no extra logic; the interface matches the list above.

Test Plan:
- Reset then push 0xA5A5_0001 with src_rdy=1 -> src_vld=1, src_data=0xA5A5_0001 one cycle later, count=1, then 0 after the pop.
- src_rdy=0, push 0x10..0x14 (5 beats, DEPTH=4) -> count=5, m_rsp_rdy=0, almost_full=1. A 6th beat held by upstream is not accepted. Then src_rdy=1 -> outputs 0x10..0x14 in order, one per cycle.
- Streaming 100 beats with src_rdy=1 and m_rsp_vld=1 -> one beat per cycle, count constant at 1, no loss or reorder.
- Random src_rdy toggling with 64 beats, wrapping pointers several times -> data matches a scoreboard; src_data is stable on stalled cycles.
- Buffer at count=3, assert flush for 1 cycle with m_rsp_vld=1 -> count=0, src_vld=0, flush-cycle beat not accepted. The next beat, 0xBEEF, emerges first.
- Assert rst mid-burst at count=4 -> all outputs reset immediately (async). With HWM_EN: hwm=4 before reset, 0 after.
